// File: rtl/cop2_issue.sv
`default_nettype none
// ============================================================================
// Module   : cop2_issue
// Function : Issue/transfer sequencer between the CPU pipeline and the GTE
//            coprocessor. It decodes COP2 instructions (MFC2/CFC2/MTC2/CTC2,
//            GTE commands, LWC2/SWC2), stalls the pipeline while a transfer
//            is in flight and routes data to/from the GTE.
// Option   : COP2_TIMEOUT_EN -- when defined, a WAIT_OUT watchdog aborts a
//            read after 255 idle cycles and pulses err.
// Revision : 1.0 - initial release
// ============================================================================
module cop2_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic [31:0] rt_data,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid,
  output logic        cpu_stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rt,
  output logic [31:0] wb_data,
  output logic        st_valid,
  output logic [31:0] st_data,
  output logic        cfc2,
  output logic        ctc2,
  output logic        mfc2,
  output logic        mtc2,
  output logic        lwc2,
  output logic        swc2,
  output logic        inst_rdy,
  output logic        gte_sf,
  output logic        gte_lm,
  output logic [1:0]  gte_mx,
  output logic [1:0]  gte_vx,
  output logic [1:0]  gte_tx,
  output logic [5:0]  gte_cmd,
  output logic [4:0]  rd,
  output logic [31:0] reg_in,
  output logic        reg_in_rdy,
  input  logic [31:0] reg_out,
  input  logic        stalled,
  input  logic        out_avail,
  output logic        err
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LOAD_WAIT = 2'd1;
  localparam logic [1:0] S_ISSUE     = 2'd2;
  localparam logic [1:0] S_WAIT_OUT  = 2'd3;

  localparam logic [2:0] K_MFC2 = 3'd0;
  localparam logic [2:0] K_CFC2 = 3'd1;
  localparam logic [2:0] K_MTC2 = 3'd2;
  localparam logic [2:0] K_CTC2 = 3'd3;
  localparam logic [2:0] K_LWC2 = 3'd4;
  localparam logic [2:0] K_SWC2 = 3'd5;
  localparam logic [2:0] K_CMD  = 3'd6;

  logic [1:0]  state_q, state_d;
  logic [2:0]  kind_q, kind_d;
  logic [4:0]  rd_q, rd_d;
  logic [4:0]  wb_rt_q, wb_rt_d;
  logic        sf_q, sf_d, lm_q, lm_d;
  logic [1:0]  mx_q, mx_d, vx_q, vx_d, tx_q, tx_d;
  logic [5:0]  cmd_q, cmd_d;
  logic [31:0] reg_in_q, reg_in_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [31:0] st_data_q, st_data_d;
  logic        wb_valid_q, wb_valid_d;
  logic        st_valid_q, st_valid_d;

  logic        dec_cop2;
  logic [2:0]  dec_kind;
  logic        fire;
  logic        tmo_hit;
  logic        unused_bits;

  // Bits [9:6] carry no meaning for any COP2 form handled here.
  assign unused_bits = ^instr[9:6];

  // Classify the offered instruction; anything not listed is not ours.
  always_comb begin
    dec_cop2 = 1'b0;
    dec_kind = K_CMD;
    case (instr[31:26])
      6'b010010: begin
        if (instr[25]) begin
          dec_cop2 = 1'b1;
          dec_kind = K_CMD;
        end else begin
          case (instr[25:21])
            5'b00000: begin dec_cop2 = 1'b1; dec_kind = K_MFC2; end
            5'b00010: begin dec_cop2 = 1'b1; dec_kind = K_CFC2; end
            5'b00100: begin dec_cop2 = 1'b1; dec_kind = K_MTC2; end
            5'b00110: begin dec_cop2 = 1'b1; dec_kind = K_CTC2; end
            default:  dec_cop2 = 1'b0;
          endcase
        end
      end
      6'b110010: begin dec_cop2 = 1'b1; dec_kind = K_LWC2; end
      6'b111010: begin dec_cop2 = 1'b1; dec_kind = K_SWC2; end
      default:   dec_cop2 = 1'b0;
    endcase
  end

  // Strobe cycle: the GTE is not stalled while we sit in ISSUE.
  assign fire = (state_q == S_ISSUE) && !stalled;

`ifdef COP2_TIMEOUT_EN
  logic [7:0] tmo_cnt_q;

  // Count cycles spent waiting for GTE read data; cleared everywhere else.
  always_ff @(posedge clk) begin
    if (rst || (state_q != S_WAIT_OUT)) begin
      tmo_cnt_q <= 8'd0;
    end else if (tmo_cnt_q != 8'hFF) begin
      tmo_cnt_q <= tmo_cnt_q + 8'd1;
    end
  end

  // Data arriving on the last allowed cycle still wins over the timeout.
  assign tmo_hit = (state_q == S_WAIT_OUT) && (tmo_cnt_q == 8'hFF) && !out_avail;
`else
  assign tmo_hit = 1'b0;
`endif

  // Next-state and datapath capture for the issue sequence.
  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    rd_d       = rd_q;
    wb_rt_d    = wb_rt_q;
    sf_d       = sf_q;
    lm_d       = lm_q;
    mx_d       = mx_q;
    vx_d       = vx_q;
    tx_d       = tx_q;
    cmd_d      = cmd_q;
    reg_in_d   = reg_in_q;
    wb_data_d  = wb_data_q;
    st_data_d  = st_data_q;
    wb_valid_d = 1'b0;
    st_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (instr_valid && dec_cop2) begin
          kind_d   = dec_kind;
          rd_d     = ((dec_kind == K_LWC2) || (dec_kind == K_SWC2)) ? instr[20:16] : instr[15:11];
          wb_rt_d  = instr[20:16];
          sf_d     = instr[19];
          mx_d     = instr[18:17];
          vx_d     = instr[16:15];
          tx_d     = instr[14:13];
          lm_d     = instr[10];
          cmd_d    = instr[5:0];
          reg_in_d = rt_data;
          state_d  = (dec_kind == K_LWC2) ? S_LOAD_WAIT : S_ISSUE;
        end
      end
      S_LOAD_WAIT: begin
        if (mem_valid) begin
          reg_in_d = mem_rdata;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!stalled) begin
          if ((kind_q == K_MFC2) || (kind_q == K_CFC2) || (kind_q == K_SWC2)) begin
            state_d = S_WAIT_OUT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT_OUT: begin
        if (out_avail) begin
          if (kind_q == K_SWC2) begin
            st_data_d  = reg_out;
            st_valid_d = 1'b1;
          end else begin
            wb_data_d  = reg_out;
            wb_valid_d = 1'b1;
          end
          state_d = S_IDLE;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset clears every field and pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      kind_q     <= K_MFC2;
      rd_q       <= 5'd0;
      wb_rt_q    <= 5'd0;
      sf_q       <= 1'b0;
      lm_q       <= 1'b0;
      mx_q       <= 2'd0;
      vx_q       <= 2'd0;
      tx_q       <= 2'd0;
      cmd_q      <= 6'd0;
      reg_in_q   <= 32'd0;
      wb_data_q  <= 32'd0;
      st_data_q  <= 32'd0;
      wb_valid_q <= 1'b0;
      st_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      rd_q       <= rd_d;
      wb_rt_q    <= wb_rt_d;
      sf_q       <= sf_d;
      lm_q       <= lm_d;
      mx_q       <= mx_d;
      vx_q       <= vx_d;
      tx_q       <= tx_d;
      cmd_q      <= cmd_d;
      reg_in_q   <= reg_in_d;
      wb_data_q  <= wb_data_d;
      st_data_q  <= st_data_d;
      wb_valid_q <= wb_valid_d;
      st_valid_q <= st_valid_d;
    end
  end

  assign cpu_stall  = (state_q != S_IDLE);
  assign mfc2       = fire && (kind_q == K_MFC2);
  assign cfc2       = fire && (kind_q == K_CFC2);
  assign mtc2       = fire && (kind_q == K_MTC2);
  assign ctc2       = fire && (kind_q == K_CTC2);
  assign lwc2       = fire && (kind_q == K_LWC2);
  assign swc2       = fire && (kind_q == K_SWC2);
  assign inst_rdy   = fire && (kind_q == K_CMD);
  assign reg_in_rdy = fire && ((kind_q == K_MTC2) || (kind_q == K_CTC2) || (kind_q == K_LWC2));
  assign reg_in     = reg_in_q;
  assign rd         = rd_q;
  assign wb_rt      = wb_rt_q;
  assign wb_data    = wb_data_q;
  assign wb_valid   = wb_valid_q;
  assign st_data    = st_data_q;
  assign st_valid   = st_valid_q;
  assign gte_sf     = sf_q;
  assign gte_lm     = lm_q;
  assign gte_mx     = mx_q;
  assign gte_vx     = vx_q;
  assign gte_tx     = tx_q;
  assign gte_cmd    = cmd_q;
  assign err        = tmo_hit;

endmodule
`default_nettype wire

// File: tb/tb_cop2_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_cop2_issue
// Function : Scoreboard bench for cop2_issue. The driver builds each
//            instruction from chosen fields, predicts every output event
//            (strobe, writeback, store, timeout) with its cycle number and
//            queues it; an independent monitor compares events as they occur.
// Option   : COP2_TIMEOUT_EN -- selects timeout expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cop2_issue;

  localparam int K_MFC2 = 0, K_CFC2 = 1, K_MTC2 = 2, K_CTC2 = 3;
  localparam int K_LWC2 = 4, K_SWC2 = 5, K_CMD = 6;
  localparam int EV_WB = 7, EV_ST = 8, EV_ERR = 9;
`ifdef COP2_TIMEOUT_EN
  localparam int TMO_EN = 1;
`else
  localparam int TMO_EN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr, rt_data, mem_rdata, reg_out;
  logic        instr_valid, mem_valid, stalled, out_avail;
  logic        cpu_stall, wb_valid, st_valid, reg_in_rdy, err, inst_rdy;
  logic        cfc2, ctc2, mfc2, mtc2, lwc2, swc2;
  logic [4:0]  wb_rt, rd;
  logic [31:0] wb_data, st_data, reg_in;
  logic        gte_sf, gte_lm;
  logic [1:0]  gte_mx, gte_vx, gte_tx;
  logic [5:0]  gte_cmd;

  cop2_issue dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .rt_data(rt_data), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .cpu_stall(cpu_stall), .wb_valid(wb_valid), .wb_rt(wb_rt), .wb_data(wb_data),
    .st_valid(st_valid), .st_data(st_data),
    .cfc2(cfc2), .ctc2(ctc2), .mfc2(mfc2), .mtc2(mtc2), .lwc2(lwc2), .swc2(swc2),
    .inst_rdy(inst_rdy), .gte_sf(gte_sf), .gte_lm(gte_lm), .gte_mx(gte_mx),
    .gte_vx(gte_vx), .gte_tx(gte_tx), .gte_cmd(gte_cmd), .rd(rd),
    .reg_in(reg_in), .reg_in_rdy(reg_in_rdy), .reg_out(reg_out),
    .stalled(stalled), .out_avail(out_avail), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          mask;
    int          cyc;
    logic [4:0]  rd;
    logic        rin_rdy;
    logic [31:0] data;
    logic [5:0]  cmd;
    logic        sf, lm;
    logic [1:0]  mx, vx, tx;
    logic [4:0]  wb_rt;
  } exp_t;

  typedef struct {
    int          kind;
    logic [4:0]  rd, rt;
    logic [31:0] rt_data, fill, mem_data, out_data;
    logic        sf, lm;
    logic [1:0]  mx, vx, tx;
    logic [5:0]  cmd;
    int          sd, md, od;
  } txn_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.kind = $urandom_range(0, 6);
    t.rd = 5'($urandom); t.rt = 5'($urandom);
    t.rt_data = $urandom; t.fill = $urandom;
    t.mem_data = $urandom; t.out_data = $urandom;
    t.sf = 1'($urandom); t.lm = 1'($urandom);
    t.mx = 2'($urandom); t.vx = 2'($urandom); t.tx = 2'($urandom);
    t.cmd = 6'($urandom);
    t.sd = $urandom_range(0, 3); t.md = $urandom_range(0, 3); t.od = $urandom_range(1, 5);
    return t;
  endfunction

  // Assemble the instruction word from the chosen transaction fields.
  function automatic logic [31:0] build_instr(input txn_t t);
    logic [31:0] w;
    w = t.fill;
    case (t.kind)
      K_MFC2: w = {6'b010010, 5'b00000, t.rt, t.rd, w[10:0]};
      K_CFC2: w = {6'b010010, 5'b00010, t.rt, t.rd, w[10:0]};
      K_MTC2: w = {6'b010010, 5'b00100, t.rt, t.rd, w[10:0]};
      K_CTC2: w = {6'b010010, 5'b00110, t.rt, t.rd, w[10:0]};
      K_LWC2: w = {6'b110010, w[25:21], t.rd, w[15:0]};
      K_SWC2: w = {6'b111010, w[25:21], t.rd, w[15:0]};
      default: w = {6'b010010, 1'b1, w[24:20], t.sf, t.mx, t.vx, t.tx, w[12:11], t.lm, w[9:6], t.cmd};
    endcase
    return w;
  endfunction

  function automatic logic [31:0] noncop2();
    logic [31:0] r;
    logic [5:0]  ops [4];
    logic [3:0]  badrs [4];
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b010000; ops[3] = 6'b101011;
    badrs[0] = 4'b0001; badrs[1] = 4'b0011; badrs[2] = 4'b1000; badrs[3] = 4'b0101;
    r = $urandom;
    if ($urandom_range(0, 1) == 0) return {ops[$urandom_range(0, 3)], r[25:0]};
    return {6'b010010, 1'b0, badrs[$urandom_range(0, 3)], r[20:0]};
  endfunction

  function automatic exp_t strobe_exp(input txn_t t, input int s);
    exp_t e;
    e.mask = 1 << t.kind; e.cyc = s; e.rd = t.rd;
    e.rin_rdy = (t.kind == K_MTC2) || (t.kind == K_CTC2) || (t.kind == K_LWC2);
    e.data = (t.kind == K_LWC2) ? t.mem_data : t.rt_data;
    e.cmd = t.cmd; e.sf = t.sf; e.lm = t.lm; e.mx = t.mx; e.vx = t.vx; e.tx = t.tx;
    e.wb_rt = t.rt;
    return e;
  endfunction

  task automatic quiet();
    instr_valid = 1'b0; mem_valid = 1'b0; out_avail = 1'b0; stalled = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctrl"}, {20'd0, cpu_stall, wb_valid, st_valid, mfc2, cfc2, mtc2, ctc2,
                         lwc2, swc2, inst_rdy, reg_in_rdy, err}, 32'd0);
    chk({tag, "_rd"}, 32'(rd), 32'd0);
    chk({tag, "_wb_rt"}, 32'(wb_rt), 32'd0);
    chk({tag, "_reg_in"}, reg_in, 32'd0);
    chk({tag, "_wb_data"}, wb_data, 32'd0);
    chk({tag, "_st_data"}, st_data, 32'd0);
    chk({tag, "_fields"}, 32'({gte_sf, gte_lm, gte_mx, gte_vx, gte_tx, gte_cmd}), 32'd0);
  endtask

  // Offer one transaction and play the GTE/memory side with chosen delays.
  task automatic run_txn(input txn_t t);
    int a, iss, s, fin, n;
    bit rdk, tmo;
    exp_t e;
    rdk = (t.kind == K_MFC2) || (t.kind == K_CFC2) || (t.kind == K_SWC2);
    tmo = rdk && (TMO_EN != 0) && (t.od >= 256);
    chk("idle_before_issue", 32'(cpu_stall), 32'd0);
    if ($urandom_range(0, 2) == 0) begin
      instr_valid = 1'b1; instr = noncop2(); rt_data = $urandom;
      @(posedge clk); #1;
      chk("noncop2_ignored", 32'(cpu_stall), 32'd0);
    end
    instr_valid = 1'b1; instr = build_instr(t); rt_data = t.rt_data;
    a   = cyc + 1;
    iss = (t.kind == K_LWC2) ? a + t.md + 1 : a;
    s   = iss + t.sd;
    fin = !rdk ? s : (tmo ? s + 256 : s + t.od);
    sb.push_back(strobe_exp(t, s));
    if (rdk) begin
      e = strobe_exp(t, s);
      e.data = t.out_data;
      if (tmo) begin e.mask = 1 << EV_ERR; e.cyc = s + 256; end
      else begin e.mask = (t.kind == K_SWC2) ? (1 << EV_ST) : (1 << EV_WB); e.cyc = s + t.od + 1; end
      sb.push_back(e);
    end
    @(posedge clk); #1;
    while (cyc <= fin) begin
      n = cyc;
      instr_valid = 1'($urandom_range(0, 1));
      instr = {6'b010010, 26'($urandom)};
      rt_data = $urandom;
      if ((t.kind == K_LWC2) && (n < iss)) begin
        mem_valid = (n == iss - 1);
        mem_rdata = (n == iss - 1) ? t.mem_data : $urandom;
      end else begin
        mem_valid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      end
      if ((n >= iss) && (n <= s)) stalled = (n < s);
      else stalled = 1'($urandom_range(0, 1));
      if (rdk && (n > s)) begin
        out_avail = !tmo && (n == s + t.od);
        reg_out = out_avail ? t.out_data : $urandom;
      end else begin
        out_avail = 1'($urandom_range(0, 1)); reg_out = $urandom;
      end
      chk("cpu_stall_busy", 32'(cpu_stall), 32'd1);
      @(posedge clk); #1;
    end
    quiet();
    chk("cpu_stall_release", 32'(cpu_stall), 32'd0);
  endtask

  // Monitor: every visible event must match the head of the scoreboard.
  logic [9:0] obs;
  exp_t       me;
  always @(negedge clk) begin
    obs = {err, st_valid, wb_valid, inst_rdy, swc2, lwc2, ctc2, mtc2, cfc2, mfc2};
    if (obs != 10'd0) begin
      if (sb.size() == 0) begin
        chk("unexpected_event", 32'(obs), 32'd0);
      end else begin
        me = sb.pop_front();
        chk("event_kind", 32'(obs), 32'(me.mask));
        chk("event_cycle", 32'(cyc), 32'(me.cyc));
        if ((me.mask & 32'h3F) != 0) begin
          chk("rd", 32'(rd), 32'(me.rd));
          chk("reg_in_rdy", 32'(reg_in_rdy), 32'(me.rin_rdy));
          if (me.rin_rdy) chk("reg_in", reg_in, me.data);
        end
        if ((me.mask & (1 << K_CMD)) != 0) begin
          chk("reg_in_rdy_cmd", 32'(reg_in_rdy), 32'd0);
          chk("gte_cmd", 32'(gte_cmd), 32'(me.cmd));
          chk("gte_fields", 32'({gte_sf, gte_mx, gte_vx, gte_tx, gte_lm}),
              32'({me.sf, me.mx, me.vx, me.tx, me.lm}));
        end
        if ((me.mask & (1 << EV_WB)) != 0) begin
          chk("wb_rt", 32'(wb_rt), 32'(me.wb_rt));
          chk("wb_data", wb_data, me.data);
        end
        if ((me.mask & (1 << EV_ST)) != 0) chk("st_data", st_data, me.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    int   a;
    rst = 1'b1; quiet();
    instr = 32'd0; rt_data = 32'd0; mem_rdata = 32'd0; reg_out = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // MTC2 with immediate issue.
    t = rand_txn(); t.kind = K_MTC2; t.rt_data = 32'h1234_5678; t.rd = 5'd9; t.sd = 0;
    run_txn(t);
    // MFC2 with data three cycles after the strobe.
    t = rand_txn(); t.kind = K_MFC2; t.rd = 5'd7; t.sd = 0; t.od = 3; t.out_data = 32'hDEAD_BEEF;
    run_txn(t);
    // Command 0x4A48_0012 held off by the GTE for four cycles.
    t = rand_txn(); t.kind = K_CMD; t.fill = 32'h0040_0000; t.sd = 4;
    t.sf = 1'b1; t.mx = 2'd0; t.vx = 2'd0; t.tx = 2'd0; t.lm = 1'b0; t.cmd = 6'h12;
    run_txn(t);
    // LWC2 with memory data two cycles after acceptance.
    t = rand_txn(); t.kind = K_LWC2; t.rd = 5'd3; t.md = 2; t.sd = 0; t.mem_data = 32'h0000_00FF;
    run_txn(t);

    // SWC2 abandoned by reset while waiting for GTE data.
    t = rand_txn(); t.kind = K_SWC2; t.sd = 0;
    chk("idle_before_swc2", 32'(cpu_stall), 32'd0);
    instr_valid = 1'b1; instr = build_instr(t);
    a = cyc + 1;
    sb.push_back(strobe_exp(t, a));
    @(posedge clk); #1;
    instr_valid = 1'b0; stalled = 1'b0; out_avail = 1'b0;
    @(posedge clk); #1;
    chk("cpu_stall_wait_out", 32'(cpu_stall), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_all_zero("rst_abort");
    out_avail = 1'b1; reg_out = $urandom;
    repeat (3) @(posedge clk);
    #1;
    out_avail = 1'b0;
    chk("idle_after_abort", 32'(cpu_stall), 32'd0);

    // CFC2 whose data never comes within the timeout window.
    t = rand_txn(); t.kind = K_CFC2; t.sd = 0; t.od = 300;
    run_txn(t);

    for (int i = 0; i < 60; i++) begin
      run_txn(rand_txn());
    end

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
